// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: control, memory and instruction handshake signals of fetch_ctrl.
// FETCH_CNT_EN adds the fetch_cnt handshake counter.
interface fetch_ctrl_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              start;
  logic              halt;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc;
  logic              busy;
`ifdef FETCH_CNT_EN
  logic [15:0]       fetch_cnt;
`endif
  modport master (
    input  start, halt, jump, jump_addr, mem_rdata, instr_ready,
`ifdef FETCH_CNT_EN
    output fetch_cnt,
`endif
    output mem_rd, mem_addr, instr, instr_valid, pc, busy
  );
  modport slave (
    output start, halt, jump, jump_addr, mem_rdata, instr_ready,
`ifdef FETCH_CNT_EN
    input  fetch_cnt,
`endif
    input  mem_rd, mem_addr, instr, instr_valid, pc, busy
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer issuing fixed-latency memory reads and presenting words on valid/ready.
// FETCH_CNT_EN adds a saturating count of accepted instructions.
module fetch_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, VALID} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, jt_q, jt_d, jt_eff;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d, jp_q, jp_d, hp_q, hp_d, jp_eff, hp_eff;
  logic [1:0]        cnt_q, cnt_d;

  // a jump or halt arriving this cycle counts as already pending
  assign jp_eff = jp_q | bus.jump;
  assign jt_eff = bus.jump ? bus.jump_addr : jt_q;
  assign hp_eff = hp_q | bus.halt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    jp_d    = jp_q;
    jt_d    = jt_q;
    hp_d    = hp_q;
    case (state_q)
      IDLE: state_d = bus.start ? ISSUE : IDLE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 2'(MEM_LAT - 1);
        jp_d    = jp_eff;
        jt_d    = jt_eff;
        hp_d    = hp_eff;
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        jp_d  = jp_eff;
        jt_d  = jt_eff;
        hp_d  = hp_eff;
        if (cnt_q == 2'd0) begin
          if (jp_eff) begin
            pc_d    = jt_eff;
            jp_d    = 1'b0;
            state_d = hp_eff ? IDLE : ISSUE;
          end else begin
            instr_d = bus.mem_rdata;
            valid_d = 1'b1;
            state_d = VALID;
          end
        end
      end
      VALID: begin
        hp_d = hp_eff;
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          pc_d    = bus.jump ? bus.jump_addr : (jp_q ? jt_q : pc_q + ADDR_W'(1));
          jp_d    = 1'b0;
          state_d = hp_eff ? IDLE : ISSUE;
        end else if (bus.jump) begin
          valid_d = 1'b0;
          pc_d    = bus.jump_addr;
          state_d = ISSUE;
        end
      end
    endcase
    if (state_d == IDLE) begin
      hp_d = 1'b0;
      jp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 2'd0;
      jp_q    <= 1'b0;
      jt_q    <= '0;
      hp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      jp_q    <= jp_d;
      jt_q    <= jt_d;
      hp_q    <= hp_d;
    end
  end

  assign bus.mem_rd      = state_q == ISSUE;
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = state_q != IDLE;

`ifdef FETCH_CNT_EN
  logic [15:0] fc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) fc_q <= '0;
    else if (valid_q && bus.instr_ready && fc_q != 16'hFFFF) fc_q <= fc_q + 16'd1;
  end
  assign bus.fetch_cnt = fc_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized fetch sequences checked against an expected-PC model.
module tb_fetch_ctrl;
`ifdef FETCH_CNT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus();
  fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [7:0] mem [256];
  logic [7:0] pipe [4];
  always @(posedge clk) begin
    pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  int checks = 0, errors = 0, cyc = 0, issue_cyc = 0, acc = 0;
  logic [7:0] pc_exp;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd) issue_cyc <= cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // entry: DUT in ISSUE for pc_exp; act 0 accept, 1 accept+jump, 2 accept+halt, 3 flush, 4 accept+halt+jump
  task automatic fetch(input int stall, input int act, input logic [7:0] ja);
    logic [7:0] ins;
    int n;
    chk("issue_rd", bus.mem_rd, 1);
    chk("issue_addr", bus.mem_addr, pc_exp);
    chk("busy", bus.busy, 1);
    tick();
    chk("rd_pulse", bus.mem_rd, 0);
    n = 0;
    while (!bus.instr_valid && n < 12) begin
      tick();
      n++;
    end
    chk("valid_timeout", bus.instr_valid, 1);
    chk("latency", cyc - issue_cyc, LAT + 1);
    chk("instr", bus.instr, mem[pc_exp]);
    chk("pc", bus.pc, pc_exp);
    ins = bus.instr;
    repeat (stall) begin
      tick();
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_instr", bus.instr, ins);
      chk("hold_pc", bus.pc, pc_exp);
      chk("hold_rd", bus.mem_rd, 0);
    end
    bus.instr_ready = act != 3;
    bus.jump = act == 1 || act == 3 || act == 4;
    bus.jump_addr = ja;
    bus.halt = act == 2 || act == 4;
    tick();
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    bus.halt = 1'b0;
    if (act != 3) acc++;
    pc_exp = (act == 0 || act == 2) ? pc_exp + 8'd1 : ja;
    chk("drop_valid", bus.instr_valid, 0);
    if (act == 2 || act == 4) begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_pc", bus.pc, pc_exp);
      chk("idle_rd", bus.mem_rd, 0);
      bus.jump = 1'b1;
      bus.halt = 1'b1;
      bus.jump_addr = ~pc_exp;
      repeat (2) tick();
      bus.jump = 1'b0;
      bus.halt = 1'b0;
      chk("idle_stay", bus.busy, 0);
      chk("idle_ignore_jump", bus.pc, pc_exp);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
  endtask

  // entry: DUT in ISSUE; jump t1 during ISSUE, optionally t2 during first WAIT cycle
  task automatic jif(input logic [7:0] t1, input logic [7:0] t2, input bit two);
    bit saw;
    int n;
    chk("jif_rd", bus.mem_rd, 1);
    chk("jif_start_addr", bus.mem_addr, pc_exp);
    bus.jump = 1'b1;
    bus.jump_addr = t1;
    tick();
    saw = bus.instr_valid;
    bus.jump = two;
    bus.jump_addr = t2;
    tick();
    bus.jump = 1'b0;
    n = 0;
    while (!bus.mem_rd && n < 12) begin
      saw |= bus.instr_valid;
      tick();
      n++;
    end
    pc_exp = two ? t2 : t1;
    chk("jif_timeout", bus.mem_rd, 1);
    chk("jif_no_valid", saw, 0);
    chk("jif_addr", bus.mem_addr, pc_exp);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA0;
    mem[1] = 8'hA1;
    mem[2] = 8'hA2;
    mem[8'h40] = 8'h5C;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.jump = 1'b0;
    bus.jump_addr = '0;
    bus.instr_ready = 1'b0;
    repeat (2) tick();
    chk("rst_pc", bus.pc, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", bus.busy, 0);
    pc_exp = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) fetch(0, 0, 8'h00);
`ifdef FETCH_CNT_EN
    chk("cnt_linear", bus.fetch_cnt, acc);
`endif
    fetch(5, 0, 8'h00);
    jif(8'h40, 8'h40, 1'b0);
    fetch(0, 0, 8'h00);
    jif(8'hFF, 8'hFF, 1'b0);
    fetch(0, 0, 8'h00);
    chk("wrap_addr", bus.mem_addr, 8'h00);
    jif(8'hFF, 8'hFF, 1'b0);
    fetch(0, 2, 8'h00);
    chk("wrap_resume", bus.mem_addr, 8'h00);
    jif(8'h10, 8'h20, 1'b1);
    fetch(1, 3, 8'h33);
    fetch(0, 4, 8'h77);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 2) jif(8'($urandom), 8'($urandom), 1'($urandom));
      else begin
        r = $urandom_range(0, 11);
        fetch($urandom_range(0, 3), r < 6 ? 0 : r < 8 ? 1 : r == 8 ? 2 : r < 11 ? 3 : 4, 8'($urandom));
      end
    end
`ifdef FETCH_CNT_EN
    chk("cnt_total", bus.fetch_cnt, acc);
`endif
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst2_pc", bus.pc, 0);
    chk("rst2_rd", bus.mem_rd, 0);
    chk("rst2_valid", bus.instr_valid, 0);
    chk("rst2_busy", bus.busy, 0);
`ifdef FETCH_CNT_EN
    chk("rst2_cnt", bus.fetch_cnt, 0);
`endif
    pc_exp = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    fetch(0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
